// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: drives the PC into instruction memory and fills the IF/ID register.
// A one-entry skid buffer holds a response that arrives while IF/ID is stalled.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {ST_REQ, ST_FULL, ST_DROP} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] tgt_pc;
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;

    logic        ack_v;
    logic [31:0] redir_al;

    // An ack only counts against a request actually on the bus.
    assign ack_v     = imem_ack & imem_req;
    assign redir_al  = {redirect_pc[31:2], 2'b00};
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_REQ;
            pc         <= RESET_PC;
            tgt_pc     <= RESET_PC;
            imem_req   <= 1'b0;
            if_valid   <= 1'b0;
            if_pc      <= 32'h0;
            if_inst    <= 32'h0;
            skid_valid <= 1'b0;
            skid_pc    <= 32'h0;
            skid_inst  <= 32'h0;
        end else if (redirect) begin
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
            imem_req   <= 1'b1;
            // Only an outstanding, unacked request forces a drop of its response.
            if (state == ST_FULL || ack_v || !imem_req) begin
                state <= ST_REQ;
                pc    <= redir_al;
            end else begin
                state  <= ST_DROP;
                tgt_pc <= redir_al;
            end
        end else begin
            case (state)
                ST_REQ: begin
                    imem_req <= 1'b1;
                    if (ack_v) begin
                        pc <= pc + 32'd4;
                        if (!if_valid || !stall) begin
                            if_valid <= 1'b1;
                            if_pc    <= pc;
                            if_inst  <= imem_rdata;
                        end else begin
                            skid_valid <= 1'b1;
                            skid_pc    <= pc;
                            skid_inst  <= imem_rdata;
                            state      <= ST_FULL;
                            imem_req   <= 1'b0;
                        end
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (!stall) begin
                        if_valid   <= skid_valid;
                        if_pc      <= skid_pc;
                        if_inst    <= skid_inst;
                        skid_valid <= 1'b0;
                        state      <= ST_REQ;
                        imem_req   <= 1'b1;
                    end
                end
                ST_DROP: begin
                    if (!stall) begin
                        if_valid <= 1'b0;
                    end
                    if (ack_v) begin
                        pc    <= tgt_pc;
                        state <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed scenarios then random traffic, checked against an
// in-order delivery queue model of the fetch stream.
module tb_pc_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    pc_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    // Model: instructions fetched but not yet consumed by decode, oldest first.
    ent_t        pend[$];
    logic [31:0] exp_next;
    logic        stale;
    logic [31:0] stale_addr;
    logic        fresh;

    int tests_run = 0;
    int tests_failed = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        exp_next   = 32'h0;
        stale      = 1'b0;
        stale_addr = 32'h0;
        fresh      = 1'b1;
    endtask

    task automatic model_check();
        check("imem_req", {31'h0, imem_req}, {31'h0, (!fresh && pend.size() < 2)});
        if (imem_req)
            check("imem_addr", imem_addr, stale ? stale_addr : exp_next);
        check("if_valid", {31'h0, if_valid}, {31'h0, (pend.size() > 0)});
        if (pend.size() > 0) begin
            check("if_pc", if_pc, pend[0].pc);
            check("if_inst", if_inst, pend[0].inst);
        end
    endtask

    // One clock: drive inputs at negedge, update the model at the edge, check at next negedge.
    task automatic step(input logic r, input logic [31:0] rpc, input logic s, input logic a);
        logic        req_b;
        logic [31:0] addr_b;
        logic        ack_e;
        ent_t        e;
        req_b  = imem_req;
        addr_b = imem_addr;
        ack_e  = a && req_b;
        redirect    = r;
        redirect_pc = rpc;
        stall       = s;
        imem_ack    = ack_e;
        imem_rdata  = ack_e ? mem_f(addr_b) : 32'hDEAD_BEEF;
        @(posedge clk);
        if (r) begin
            pend.delete();
            stale      = req_b && !ack_e;
            stale_addr = addr_b;
            exp_next   = {rpc[31:2], 2'b00};
        end else begin
            if (!s && pend.size() > 0)
                void'(pend.pop_front());
            if (ack_e) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    e.pc   = addr_b;
                    e.inst = mem_f(addr_b);
                    pend.push_back(e);
                    exp_next = addr_b + 32'd4;
                end
            end
        end
        fresh = 1'b0;
        @(negedge clk);
        redirect = 1'b0;
        imem_ack = 1'b0;
        stall    = 1'b0;
        model_check();
    endtask

    task automatic reset_checks();
        check("rst_imem_req", {31'h0, imem_req}, 32'h0);
        check("rst_if_valid", {31'h0, if_valid}, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        stall = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_checks();
        rst_n = 1'b1;

        // Reset release and back-to-back acks
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("first_req", {31'h0, imem_req}, 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("seq_pc0", if_pc, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("seq_pc4", if_pc, 32'h4);
        check("seq_v4", {31'h0, if_valid}, 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("seq_pc8", if_pc, 32'h8);
        check("seq_v8", {31'h0, if_valid}, 32'h1);

        // Stalled IF/ID absorbs the 0xC response in the skid buffer
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("full_req", {31'h0, imem_req}, 32'h0);
        check("full_hold", if_pc, 32'h8);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("full_hold2", if_pc, 32'h8);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("skid_out", if_pc, 32'hC);
        check("skid_req", imem_addr, 32'h10);

        // Redirect coincident with ack
        step(1'b1, 32'h100, 1'b0, 1'b1);
        check("redir_ack_v", {31'h0, if_valid}, 32'h0);
        check("redir_ack_addr", imem_addr, 32'h100);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("redir_first", if_pc, 32'h100);

        // Redirect while a request is outstanding
        step(1'b1, 32'h20, 1'b0, 1'b1);
        step(1'b1, 32'h200, 1'b0, 1'b0);
        check("drop_addr", imem_addr, 32'h20);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("drop_hold", imem_addr, 32'h20);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("drop_done", imem_addr, 32'h200);
        check("drop_v", {31'h0, if_valid}, 32'h0);

        // Flush beats stall
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("pre_flush", if_pc, 32'h200);
        step(1'b1, 32'h300, 1'b1, 1'b0);
        check("flush_stall", {31'h0, if_valid}, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("flush_addr", imem_addr, 32'h300);

        // Wraparound and target alignment
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        step(1'b1, 32'h103, 1'b0, 1'b1);
        check("align_addr", imem_addr, 32'h100);

        // Reset in the middle of FULL
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("pre_rst_full", {31'h0, imem_req}, 32'h0);
        rst_n = 1'b0;
        #1;
        reset_checks();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(15) == 0), $urandom, ($urandom_range(2) == 0),
                 1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
